// File: rtl/toggle_event_rx_if.sv
// rtl/toggle_event_rx_if.sv - event delivery handshake between toggle receiver and consumer
interface toggle_event_rx_if;
  logic evt_valid;
  logic evt_ready;

  modport master (output evt_valid, input evt_ready);
  modport slave  (input evt_valid, output evt_ready);
endinterface

// File: rtl/toggle_event_rx.sv
// rtl/toggle_event_rx.sv - toggle-encoded event receiver: synchronizer, edge detect,
// pending-event buffer with valid/ready delivery, delivered counter and sticky overflow.
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 3,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tgl_in,
  input  logic                 clr_ovf,
  toggle_event_rx_if.master    evt,
  output logic                 edge_pulse,
  output logic [PEND_W-1:0]    pending,
  output logic [CNT_W-1:0]     evt_count,
  output logic                 overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES - 1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   ref_lvl;
  logic                   ref_load;
  logic                   ref_src;
  logic [FILL_W-1:0]      fill_cnt;
  logic                   fill_done;
  logic                   det;
  logic                   xfer;

  assign sync_out  = sync[SYNC_STAGES-1];
  assign fill_done = (state == FILL) && (fill_cnt == FILL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tgl_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (state == FILL) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (fill_done) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = FILL;
    endcase
  end

  // On the last fill edge the reference takes the value the synchronizer output is
  // about to become, so any level present before detection starts is absorbed.
  always_comb begin
    edge_pulse = 1'b0;
    ref_load   = 1'b0;
    ref_src    = sync_out;
    case (state)
      FILL: begin
        if (fill_done) begin
          ref_load = 1'b1;
          ref_src  = sync[SYNC_STAGES-2];
        end
      end
      RUN: begin
        edge_pulse = sync_out ^ ref_lvl;
        ref_load   = 1'b1;
        ref_src    = sync_out;
      end
      default: begin
        edge_pulse = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_lvl <= 1'b0;
    end else if (ref_load) begin
      ref_lvl <= ref_src;
    end
  end

  assign evt.evt_valid = (pending != '0);
  assign det           = edge_pulse;
  assign xfer          = evt.evt_valid && evt.evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (det && !xfer && (pending != PEND_MAX)) begin
      pending <= pending + 1'b1;
    end else if (xfer && !det) begin
      pending <= pending - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_count <= '0;
    end else if (xfer) begin
      evt_count <= evt_count + 1'b1;
    end
  end

  // A drop on the same edge as a clear wins, so no dropped event goes unreported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (det && !xfer && (pending == PEND_MAX)) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// tb/tb_toggle_event_rx.sv - directed self-checking bench for toggle_event_rx
`timescale 1ns/1ps
module tb_toggle_event_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tgl_in = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       edge_pulse;
  logic [2:0] pending;
  logic [7:0] evt_count;
  logic       overflow;
  int         errors = 0;
  int         checks = 0;

  toggle_event_rx_if evt_if ();

  toggle_event_rx #(.SYNC_STAGES(2), .PEND_W(3), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tgl_in     (tgl_in),
    .clr_ovf    (clr_ovf),
    .evt        (evt_if),
    .edge_pulse (edge_pulse),
    .pending    (pending),
    .evt_count  (evt_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic lvl);
    rst = 1'b1;
    tgl_in = lvl;
    evt_if.evt_ready = 1'b0;
    clr_ovf = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic load_events(input int n);
    for (int i = 0; i < n; i++) begin
      tgl_in = ~tgl_in;
      tick(3);
    end
  endtask

  task automatic test_reset;
    int pulses;
    rst = 1'b1;
    tgl_in = 1'b1;
    evt_if.evt_ready = 1'b0;
    #1;
    checks++;
    if (pending !== 3'd0 || evt_if.evt_valid !== 1'b0 || edge_pulse !== 1'b0 ||
        evt_count !== 8'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pending=%0d valid=%b pulse=%b count=%0d ovf=%b required all 0",
               pending, evt_if.evt_valid, edge_pulse, evt_count, overflow);
    end
    tick(2);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (edge_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_held_high_pulse: pulses=%0d required 0", pulses);
    end
    checks++;
    if (pending !== 3'd0 || evt_if.evt_valid !== 1'b0 || evt_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_held_high_state: pending=%0d valid=%b count=%0d required 0/0/0",
               pending, evt_if.evt_valid, evt_count);
    end
  endtask

  task automatic test_single;
    do_reset(1'b0);
    tgl_in = 1'b1;
    tick(1);
    checks++;
    if (edge_pulse !== 1'b0 || evt_if.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_e0: pulse=%b valid=%b required 0/0", edge_pulse, evt_if.evt_valid);
    end
    tick(1);
    checks++;
    if (edge_pulse !== 1'b1 || evt_if.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_e1: pulse=%b valid=%b required 1/0", edge_pulse, evt_if.evt_valid);
    end
    tick(1);
    checks++;
    if (edge_pulse !== 1'b0 || evt_if.evt_valid !== 1'b1 || pending !== 3'd1) begin
      errors++;
      $display("FAIL single_e2: pulse=%b valid=%b pending=%0d required 0/1/1",
               edge_pulse, evt_if.evt_valid, pending);
    end
    evt_if.evt_ready = 1'b1;
    tick(1);
    evt_if.evt_ready = 1'b0;
    checks++;
    if (evt_count !== 8'd1 || pending !== 3'd0 || evt_if.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_xfer: count=%0d pending=%0d valid=%b required 1/0/0",
               evt_count, pending, evt_if.evt_valid);
    end
  endtask

  task automatic test_overflow;
    do_reset(1'b0);
    load_events(9);
    checks++;
    if (pending !== 3'd7 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_saturate: pending=%0d ovf=%b required 7/1", pending, overflow);
    end
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (evt_if.evt_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_valid_%0d: valid=%b required 1", i, evt_if.evt_valid);
      end
      tick(1);
      checks++;
      if (evt_count !== 8'(i + 1)) begin
        errors++;
        $display("FAIL drain_count_%0d: count=%0d required %0d", i, evt_count, i + 1);
      end
    end
    evt_if.evt_ready = 1'b0;
    checks++;
    if (evt_if.evt_valid !== 1'b0 || pending !== 3'd0) begin
      errors++;
      $display("FAIL drain_end: valid=%b pending=%0d required 0/0", evt_if.evt_valid, pending);
    end
  endtask

  task automatic test_det_and_xfer;
    do_reset(1'b0);
    load_events(7);
    tgl_in = ~tgl_in;
    tick(2);
    checks++;
    if (edge_pulse !== 1'b1 || pending !== 3'd7) begin
      errors++;
      $display("FAIL simul_setup: pulse=%b pending=%0d required 1/7", edge_pulse, pending);
    end
    evt_if.evt_ready = 1'b1;
    tick(1);
    evt_if.evt_ready = 1'b0;
    checks++;
    if (pending !== 3'd7 || overflow !== 1'b0 || evt_count !== 8'd1) begin
      errors++;
      $display("FAIL simul_det_xfer: pending=%0d ovf=%b count=%0d required 7/0/1",
               pending, overflow, evt_count);
    end
  endtask

  task automatic test_clr_ovf;
    tgl_in = ~tgl_in;
    tick(3);
    checks++;
    if (overflow !== 1'b1 || pending !== 3'd7) begin
      errors++;
      $display("FAIL clr_first_drop: ovf=%b pending=%0d required 1/7", overflow, pending);
    end
    tgl_in = ~tgl_in;
    tick(2);
    clr_ovf = 1'b1;
    tick(1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL clr_same_edge_drop: ovf=%b required 1", overflow);
    end
    tick(1);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: ovf=%b required 0", overflow);
    end
  endtask

  task automatic test_wrap;
    do_reset(1'b0);
    evt_if.evt_ready = 1'b1;
    load_events(255);
    tick(2);
    checks++;
    if (evt_count !== 8'd255 || overflow !== 1'b0 || pending !== 3'd0) begin
      errors++;
      $display("FAIL wrap_preload: count=%0d ovf=%b pending=%0d required 255/0/0",
               evt_count, overflow, pending);
    end
    tgl_in = ~tgl_in;
    tick(4);
    evt_if.evt_ready = 1'b0;
    checks++;
    if (evt_count !== 8'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_rollover: count=%0d ovf=%b required 0/0", evt_count, overflow);
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    load_events(4);
    checks++;
    if (pending !== 3'd4) begin
      errors++;
      $display("FAIL mid_preload: pending=%0d required 4", pending);
    end
    tgl_in = ~tgl_in;
    tick(1);
    rst = 1'b1;
    #1;
    checks++;
    if (pending !== 3'd0 || evt_if.evt_valid !== 1'b0 || edge_pulse !== 1'b0 ||
        evt_count !== 8'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: pending=%0d valid=%b pulse=%b count=%0d ovf=%b required all 0",
               pending, evt_if.evt_valid, edge_pulse, evt_count, overflow);
    end
    tick(2);
    rst = 1'b0;
    tick(2);
    tgl_in = ~tgl_in;
    tick(2);
    checks++;
    if (edge_pulse !== 1'b1) begin
      errors++;
      $display("FAIL mid_redetect_pulse: pulse=%b required 1", edge_pulse);
    end
    tick(1);
    checks++;
    if (pending !== 3'd1 || evt_if.evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_redetect_pending: pending=%0d valid=%b required 1/1",
               pending, evt_if.evt_valid);
    end
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_det_and_xfer();
    test_clr_ovf();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1, "timeout");
  end

endmodule
